// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the programmable multi-lane delay line.
// Widths derive from the delay depth so every file agrees on them.
package prog_delay_pkg;

  localparam int DEF_MAX_DELAY = 16;
  localparam int DEF_D_WIDTH   = 8;
  localparam int DEF_N_CH      = 2;

  typedef logic [DEF_N_CH*DEF_D_WIDTH-1:0] lane_t;

  function automatic int dly_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Sample/config bundle between a datapath and the delay line.
// master drives samples and delay control; slave returns the tap.
interface prog_delay_line_if #(
  parameter int MAX_DELAY = 16,
  parameter int D_WIDTH   = 8,
  parameter int N_CH      = 2
);
  import prog_delay_pkg::*;

  localparam int DW = dly_w(MAX_DELAY);
  localparam int LW = N_CH * D_WIDTH;

  logic          en;
  logic          in_valid;
  logic [LW-1:0] in;
  logic          delay_ld;
  logic [DW-1:0] delay_sel;
  logic          flush;
  logic [LW-1:0] out;
  logic          out_valid;
  logic [DW-1:0] cur_delay;
  logic          cfg_err;

  modport master (
    output en,
    output in_valid,
    output in,
    output delay_ld,
    output delay_sel,
    output flush,
    input  out,
    input  out_valid,
    input  cur_delay,
    input  cfg_err
  );

  modport slave (
    input  en,
    input  in_valid,
    input  in,
    input  delay_ld,
    input  delay_sel,
    input  flush,
    output out,
    output out_valid,
    output cur_delay,
    output cfg_err
  );

endinterface

// File: rtl/del_stage_bank.sv
// One tap of the chain: all lanes plus a shared valid bit.
// clr drops only the valid bit; data keeps following en.
module del_stage_bank #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = d_valid;
      data_d  = d_data;
    end
    if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;

endmodule

// File: rtl/prog_delay_line.sv
// Multi-lane delay line with run-time reloadable depth.
// Stage 0 is the live input; taps 1..MAX_DELAY are registered.
module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter int MAX_DELAY     = 16,
  parameter int D_WIDTH       = 8,
  parameter int N_CH          = 2,
  parameter int DEFAULT_DELAY = 2
) (
  input logic              clk,
  input logic              rst,
  prog_delay_line_if.slave io
);

  localparam int DW = dly_w(MAX_DELAY);
  localparam int LW = N_CH * D_WIDTH;

  logic          clr;
  logic          reg_valid [1:MAX_DELAY];
  logic [LW-1:0] reg_data  [1:MAX_DELAY];

  logic [DW-1:0] cur_delay_q;
  logic [DW-1:0] cur_delay_d;
  logic          cfg_err_q;
  logic          cfg_err_d;

  logic [LW-1:0] tap_data;
  logic          tap_valid;

  // A reload also invalidates the chain so old-depth data never shows.
  assign clr = io.flush | io.delay_ld;

  for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
    logic          src_valid;
    logic [LW-1:0] src_data;

    if (k == 1) begin : g_head
      assign src_valid = io.in_valid;
      assign src_data  = io.in;
    end else begin : g_link
      assign src_valid = reg_valid[k-1];
      assign src_data  = reg_data[k-1];
    end

    del_stage_bank #(
      .W (LW)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .en      (io.en),
      .clr     (clr),
      .d_valid (src_valid),
      .d_data  (src_data),
      .q_valid (reg_valid[k]),
      .q_data  (reg_data[k])
    );
  end

  always_comb begin
    cur_delay_d = cur_delay_q;
    cfg_err_d   = cfg_err_q;
    if (io.delay_ld) begin
      if (io.delay_sel > DW'(MAX_DELAY)) begin
        cur_delay_d = DW'(MAX_DELAY);
        cfg_err_d   = 1'b1;
      end else begin
        cur_delay_d = io.delay_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_delay_q <= DW'(DEFAULT_DELAY);
      cfg_err_q   <= 1'b0;
    end else begin
      cur_delay_q <= cur_delay_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // cur_delay never exceeds MAX_DELAY, so the loop covers every tap.
  always_comb begin
    tap_data  = io.in;
    tap_valid = io.in_valid;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (cur_delay_q == DW'(k)) begin
        tap_data  = reg_data[k];
        tap_valid = reg_valid[k];
      end
    end
  end

  assign io.out       = tap_data;
  assign io.out_valid = tap_valid;
  assign io.cur_delay = cur_delay_q;
  assign io.cfg_err   = cfg_err_q;

endmodule
